multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Control unit for the multicycle ARM-subset core. It wraps the existing Decoder field split (Op, Funct, Rd) in a main FSM, and adds an ALU decoder, condition-check logic and the architectural NZCV flags register.
- Sequences the shared memory port, instruction register, register file, PC and ALU over several cycles per instruction.
- Sits between the instruction register and the datapath mux/enable inputs.

Parameters:
ALUCTRL_W, 3, width of ALUControl output
FLAG_W, 4, width of flags register and ALUFlags input (N,Z,C,V order, N = MSB)

Ports:
clk  input  1  single system clock, rising edge
reset  input  1  asynchronous active-low reset
Cond  input  4  Instr[31:28]
Op  input  2  Instr[27:26]
Funct  input  6  Instr[25:20]
Rd  input  4  Instr[15:12]
ALUFlags  input  FLAG_W  ALU NZCV result of the current cycle
MemReady  input  1  memory handshake, 1 = access completes this cycle
PCWrite  output  1  PC load enable
IRWrite  output  1  instruction register load enable
RegW  output  1  register-file write enable
MemW  output  1  data memory write strobe
AdrSrc  output  1  memory address mux: 0 = PC, 1 = ALU result
ResultSrc  output  2  result mux: 00 = ALUOut, 01 = Data, 10 = ALUResult
ALUSrcA  output  1  ALU input A: 0 = register, 1 = PC
ALUSrcB  output  2  ALU input B: 00 = register, 01 = ExtImm, 10 = constant 4
ImmSrc  output  2  equals Op
RegSrc  output  2  [0] = (Op==10), [1] = (Op==01)
ALUControl  output  ALUCTRL_W  ADD 000, SUB 001, AND 010, ORR 011
Flags  output  FLAG_W  current architectural NZCV

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to FETCH and Flags goes to 0000.
  - While reset is low, PCWrite, IRWrite, RegW and MemW are forced to 0. All other outputs take their FETCH values.
  - Reset mid-instruction aborts that instruction with no partial writes.
- FSM states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH.
- FETCH:
  - Fixed outputs: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, ResultSrc=10.
  - IRWrite and PCWrite are each equal to MemReady.
  - Stays in FETCH while MemReady=0; goes to DECODE when MemReady=1.
  - PCWrite in FETCH is not condition-gated.
- DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10 (R15 reads PC+8). Next state:
  - Op=01 → MEMADR
  - Op=00 with Funct[5]=0 → EXECR
  - Op=00 with Funct[5]=1 → EXECI
  - Op=10 → BRANCH
  - Op=11 → FETCH (treated as NOP)
- MEMADR: ALUSrcA=0, ALUSrcB=01, ADD. Funct[0]=1 → MEMREAD, otherwise MEMWRITE.
- MEMREAD: AdrSrc=1. Holds until MemReady=1, then → MEMWB.
- MEMWB: ResultSrc=01, RegW=CondEx, then → FETCH.
- MEMWRITE: AdrSrc=1, MemW=CondEx held until MemReady=1, then → FETCH.
- EXECR / EXECI: ALUSrcA=0; ALUSrcB=00 in EXECR, 01 in EXECI. ALU decoder is active. Next → ALUWB.
- ALUWB:
  - ResultSrc=00.
  - RegW = CondEx & ~NoWrite & (Rd!=15).
  - PCWrite = CondEx & ~NoWrite & (Rd==15).
  - Next → FETCH.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ADD, ResultSrc=10, PCWrite=CondEx, then → FETCH.
- ALU decoder on Funct[4:1]:

  | Funct[4:1] | Operation | ALUControl | NoWrite |
  |---|---|---|---|
  | 0100 | ADD | 000 | 0 |
  | 0010 | SUB | 001 | 0 |
  | 0000 | AND | 010 | 0 |
  | 1100 | ORR | 011 | 0 |
  | 1010 | CMP | 001 | 1 |
  | any other | — | 000 | 1 |

  - Outside EXECR/EXECI the ALU decoder is inactive and ALUControl is ADD.
- FlagW:
  - Funct[0]=0 → 00.
  - Funct[0]=1 with ADD, SUB or CMP → 11.
  - Funct[0]=1 with AND or ORR → 10.
- Flags register:
  - Updates on the clock edge that leaves EXECR/EXECI, and only if CondEx=1.
  - FlagW[1] loads N and Z; FlagW[0] loads C and V.
- CondEx is combinational from Cond and the registered Flags (the pre-update value within an instruction):
  - EQ/NE, CS/CC, MI/PL, VS/VC, HI/LS, GE/LT, GT/LE per ARM definitions.
  - 1110 (AL) → 1; 1111 → 0.
- CPI: DP = 4, STR = 4, LDR = 5, B = 3 (all plus memory wait cycles).

Optional Feature:
- Macro: MC_STATE_DBG_EN.
- Defined: adds output port StateDbg (4 bits) carrying the state encoding FETCH=0 … BRANCH=9.
- Undefined: port absent; function otherwise identical.

Test Plan:
- Reset low for 2 cycles mid-EXECR, then release, MemReady=1 → FETCH with IRWrite=1 and PCWrite=1 on the first cycle; Flags=0000; no RegW pulse observed.
- 32'hE2802005 (ADD R2,R0,#5), MemReady=1 → states FETCH, DECODE, EXECI, ALUWB; ALUSrcB=01 and ALUControl=000 in EXECI; RegW=1 only in ALUWB.
- 32'hE5802064 (STR), MemReady held 0 for 3 MEMWRITE cycles → MemW=1 for 4 cycles with AdrSrc=1; RegW never asserted; returns to FETCH.
- 32'hE5902060 (LDR), MemReady=1 → FETCH, DECODE, MEMADR, MEMREAD, MEMWB; ResultSrc=01 and RegW=1 in MEMWB.
- CMP setting Z (Funct=010101, ALUFlags=0100) → Flags=0100 and RegW=0. Then 32'h1AFFFFEF (BNE) → BRANCH with PCWrite=0, back to FETCH.
- 32'hEA000001 (B) → PCWrite=1 in BRANCH with ResultSrc=10; 3 states total.

Source files
------------

// File: rtl/multicycle_controller.sv
// multicycle_controller: control unit for the multicycle ARM-subset core.
// Main FSM sequencing memory/IR/regfile/PC/ALU, plus ALU decoder,
// condition check and the architectural NZCV flags register.
// Optional build macro MC_STATE_DBG_EN adds a 4-bit StateDbg output
// carrying the state encoding (FETCH=0 ... BRANCH=9).
module multicycle_controller #(
  parameter int ALUCTRL_W = 3,
  parameter int FLAG_W    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           Cond,
  input  logic [1:0]           Op,
  input  logic [5:0]           Funct,
  input  logic [3:0]           Rd,
  input  logic [FLAG_W-1:0]    ALUFlags,
  input  logic                 MemReady,
  output logic                 PCWrite,
  output logic                 IRWrite,
  output logic                 RegW,
  output logic                 MemW,
  output logic                 AdrSrc,
  output logic [1:0]           ResultSrc,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ImmSrc,
  output logic [1:0]           RegSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic [FLAG_W-1:0]    Flags
`ifdef MC_STATE_DBG_EN
  ,
  output logic [3:0]           StateDbg
`endif
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;

  localparam logic [ALUCTRL_W-1:0] ALU_ADD = ALUCTRL_W'(0);
  localparam logic [ALUCTRL_W-1:0] ALU_SUB = ALUCTRL_W'(1);
  localparam logic [ALUCTRL_W-1:0] ALU_AND = ALUCTRL_W'(2);
  localparam logic [ALUCTRL_W-1:0] ALU_ORR = ALUCTRL_W'(3);

  state_t                 state_q, state_d;
  logic [FLAG_W-1:0]      flags_q, flags_d;
  logic                   condex_q, condex_d;
  logic                   condex;
  logic                   in_exec;
  logic [ALUCTRL_W-1:0]   dec_alu;
  logic                   dec_nowrite;
  logic [1:0]             flag_w;
  logic                   pcw, irw, regw, memw;

  // ARM condition-field evaluation against NZCV
  function automatic logic cond_check(input logic [3:0] c, input logic n,
                                      input logic z, input logic cy,
                                      input logic v);
    logic r;
    case (c)
      4'b0000: r = z;
      4'b0001: r = ~z;
      4'b0010: r = cy;
      4'b0011: r = ~cy;
      4'b0100: r = n;
      4'b0101: r = ~n;
      4'b0110: r = v;
      4'b0111: r = ~v;
      4'b1000: r = cy & ~z;
      4'b1001: r = ~cy | z;
      4'b1010: r = (n == v);
      4'b1011: r = (n != v);
      4'b1100: r = ~z & (n == v);
      4'b1101: r = z | (n != v);
      4'b1110: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  assign condex  = cond_check(Cond, flags_q[FLAG_W-1], flags_q[FLAG_W-2],
                              flags_q[FLAG_W-3], flags_q[FLAG_W-4]);
  assign in_exec = (state_q == EXECR) || (state_q == EXECI);

  // ALU decoder: operation, write suppression and flag-write enables
  always_comb begin
    dec_alu     = ALU_ADD;
    dec_nowrite = 1'b1;
    flag_w      = 2'b00;
    case (Funct[4:1])
      4'b0100: begin dec_alu = ALU_ADD; dec_nowrite = 1'b0; flag_w = {2{Funct[0]}}; end
      4'b0010: begin dec_alu = ALU_SUB; dec_nowrite = 1'b0; flag_w = {2{Funct[0]}}; end
      4'b0000: begin dec_alu = ALU_AND; dec_nowrite = 1'b0; flag_w = {Funct[0], 1'b0}; end
      4'b1100: begin dec_alu = ALU_ORR; dec_nowrite = 1'b0; flag_w = {Funct[0], 1'b0}; end
      4'b1010: begin dec_alu = ALU_SUB; dec_nowrite = 1'b1; flag_w = {2{Funct[0]}}; end
      default: begin dec_alu = ALU_ADD; dec_nowrite = 1'b1; flag_w = 2'b00; end
    endcase
  end

  // Flags load on the edge leaving EXECR/EXECI; the condition result is kept
  // so ALUWB still judges against the pre-update flags of this instruction
  always_comb begin
    flags_d  = flags_q;
    condex_d = condex_q;
    if (in_exec) begin
      condex_d = condex;
      if (condex) begin
        if (flag_w[1]) flags_d[FLAG_W-1:FLAG_W-2] = ALUFlags[FLAG_W-1:FLAG_W-2];
        if (flag_w[0]) flags_d[FLAG_W-3:FLAG_W-4] = ALUFlags[FLAG_W-3:FLAG_W-4];
      end
    end
  end

  // State, flags and latched condition registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= FETCH;
      flags_q  <= '0;
      condex_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      flags_q  <= flags_d;
      condex_q <= condex_d;
    end
  end

  // Next-state and datapath control decode
  always_comb begin
    state_d   = state_q;
    pcw       = 1'b0;
    irw       = 1'b0;
    regw      = 1'b0;
    memw      = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    case (state_q)
      FETCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        irw       = MemReady;
        pcw       = MemReady;
        if (MemReady) state_d = DECODE;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        case (Op)
          2'b01:   state_d = MEMADR;
          2'b00:   state_d = Funct[5] ? EXECI : EXECR;
          2'b10:   state_d = BRANCH;
          default: state_d = FETCH;
        endcase
      end
      MEMADR: begin
        ALUSrcB = 2'b01;
        state_d = Funct[0] ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        AdrSrc = 1'b1;
        if (MemReady) state_d = MEMWB;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        regw      = condex;
        state_d   = FETCH;
      end
      MEMWRITE: begin
        AdrSrc = 1'b1;
        memw   = condex;
        if (MemReady) state_d = FETCH;
      end
      EXECR: state_d = ALUWB;
      EXECI: begin
        ALUSrcB = 2'b01;
        state_d = ALUWB;
      end
      ALUWB: begin
        regw    = condex_q & ~dec_nowrite & (Rd != 4'd15);
        pcw     = condex_q & ~dec_nowrite & (Rd == 4'd15);
        state_d = FETCH;
      end
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        pcw       = condex;
        state_d   = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  // Write strobes are held off for as long as reset is asserted
  assign PCWrite    = pcw & reset;
  assign IRWrite    = irw & reset;
  assign RegW       = regw & reset;
  assign MemW       = memw & reset;
  assign ALUControl = in_exec ? dec_alu : ALU_ADD;
  assign ImmSrc     = Op;
  assign RegSrc     = {(Op == 2'b01), (Op == 2'b10)};
  assign Flags      = flags_q;
`ifdef MC_STATE_DBG_EN
  assign StateDbg   = state_q;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed instructions plus
// randomized instruction streams checked against a per-instruction model.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] Cond;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] ALUFlags;
  logic       MemReady;
  logic       PCWrite, IRWrite, RegW, MemW, AdrSrc, ALUSrcA;
  logic [1:0] ResultSrc, ALUSrcB, ImmSrc, RegSrc;
  logic [2:0] ALUControl;
  logic [3:0] Flags;

  multicycle_controller #(.ALUCTRL_W(3), .FLAG_W(4)) dut (
    .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
    .ALUFlags(ALUFlags), .MemReady(MemReady), .PCWrite(PCWrite),
    .IRWrite(IRWrite), .RegW(RegW), .MemW(MemW), .AdrSrc(AdrSrc),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl), .Flags(Flags)
  );

  always #5 clk = ~clk;

  // obs bit map: 16 PCW, 15 IRW, 14 RegW, 13 MemW, 12 AdrSrc, 11:10 ResultSrc,
  // 9 ALUSrcA, 8:7 ALUSrcB, 6:4 ALUControl, 3:2 ImmSrc, 1:0 RegSrc
  wire [16:0] obs = {PCWrite, IRWrite, RegW, MemW, AdrSrc, ResultSrc, ALUSrcA,
                     ALUSrcB, ALUControl, ImmSrc, RegSrc};

  localparam logic [16:0] M_ALL = 17'h1FFFF;
  localparam logic [16:0] M_ADR = ~(17'h1 << 12);
  localparam logic [16:0] M_RES = ~(17'h3 << 10);
  localparam logic [16:0] M_AB  = ~(17'h7 << 7);

  typedef struct {
    logic [16:0] e;
    logic [16:0] m;
    bit          mr;
    bit          ex;
  } rec_t;

  int         checks = 0;
  int         errors = 0;
  logic [3:0] flags_m;
  logic [1:0] op_c;
  bit         fix_en;
  logic [3:0] fix_val;

  task automatic check(input string tag, input logic [16:0] o,
                       input logic [16:0] e, input logic [16:0] m);
    checks++;
    assert ((o & m) === (e & m)) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h mask=%h", tag, o & m, e & m, m);
    end
  endtask

  // Expected output vector; ImmSrc/RegSrc follow the current opcode
  function automatic logic [16:0] ov(bit pcw, bit irw, bit regw, bit memw,
                                     bit adr, logic [1:0] res, bit a,
                                     logic [1:0] b, logic [2:0] alu);
    return {pcw, irw, regw, memw, adr, res, a, b, alu, op_c,
            (op_c == 2'b01), (op_c == 2'b10)};
  endfunction

  // ARM condition semantics: pairs of a base test and its inverse
  function automatic bit cond_ok(logic [3:0] c, logic [3:0] f);
    bit n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    if (c == 4'b1110) return 1'b1;
    if (c == 4'b1111) return 1'b0;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      default: base = !z && (n == v);
    endcase
    return c[0] ? !base : base;
  endfunction

  // Data-processing semantics from the instruction's cmd and S bit
  task automatic alu_model(input logic [5:0] f, output logic [2:0] ac,
                           output bit nw, output bit snz, output bit scv);
    ac = 3'd0; nw = 1'b1; snz = 1'b0; scv = 1'b0;
    case (f[4:1])
      4'b0100: begin ac = 3'd0; nw = 0; snz = f[0]; scv = f[0]; end
      4'b0010: begin ac = 3'd1; nw = 0; snz = f[0]; scv = f[0]; end
      4'b0000: begin ac = 3'd2; nw = 0; snz = f[0]; end
      4'b1100: begin ac = 3'd3; nw = 0; snz = f[0]; end
      4'b1010: begin ac = 3'd1; nw = 1; snz = f[0]; scv = f[0]; end
      default: ;
    endcase
  endtask

  // Runs one instruction from FETCH; abort_at >= 0 drops reset at that cycle
  task automatic run_instr(input logic [31:0] instr, input int wf,
                           input int wm, input int abort_at, input string nm);
    rec_t       q[$];
    rec_t       r;
    bit         ce, nw, snz, scv;
    logic [2:0] ac;
    logic [5:0] f;
    f     = instr[25:20];
    Cond  = instr[31:28];
    Op    = instr[27:26];
    Funct = f;
    Rd    = instr[15:12];
    op_c  = instr[27:26];
    ce    = cond_ok(instr[31:28], flags_m);
    alu_model(f, ac, nw, snz, scv);

    for (int k = 0; k < wf; k++) begin
      r = '{ov(0,0,0,0,0,2'b10,1,2'b10,0), M_ALL, 1'b0, 1'b0}; q.push_back(r);
    end
    r = '{ov(1,1,0,0,0,2'b10,1,2'b10,0), M_ALL, 1'b1, 1'b0}; q.push_back(r);
    r = '{ov(0,0,0,0,0,2'b10,1,2'b10,0), M_ADR, 1'($urandom), 1'b0}; q.push_back(r);
    case (op_c)
      2'b01: begin
        r = '{ov(0,0,0,0,0,0,0,2'b01,0), M_ADR & M_RES, 1'($urandom), 1'b0};
        q.push_back(r);
        if (f[0]) begin
          for (int k = 0; k <= wm; k++) begin
            r = '{ov(0,0,0,0,1,0,0,0,0), M_RES & M_AB, (k == wm), 1'b0};
            q.push_back(r);
          end
          r = '{ov(0,0,ce,0,0,2'b01,0,0,0), M_ADR & M_AB, 1'($urandom), 1'b0};
          q.push_back(r);
        end else begin
          for (int k = 0; k <= wm; k++) begin
            r = '{ov(0,0,0,ce,1,0,0,0,0), M_RES & M_AB, (k == wm), 1'b0};
            q.push_back(r);
          end
        end
      end
      2'b00: begin
        r = '{ov(0,0,0,0,0,0,0,{1'b0, f[5]},ac), M_ADR & M_RES, 1'($urandom), 1'b1};
        q.push_back(r);
        r = '{ov(ce && !nw && instr[15:12] == 4'd15, 0,
                 ce && !nw && instr[15:12] != 4'd15, 0,0,0,0,0,0),
              M_ADR & M_AB, 1'($urandom), 1'b0};
        q.push_back(r);
      end
      2'b10: begin
        r = '{ov(ce,0,0,0,0,2'b10,0,2'b01,0), M_ADR, 1'($urandom), 1'b0};
        q.push_back(r);
      end
      default: ;
    endcase

    for (int i = 0; i < q.size(); i++) begin
      if (i == abort_at) begin
        reset    = 1'b0;
        MemReady = 1'b1;
        flags_m  = 4'b0000;
        for (int k = 0; k < 2; k++) begin
          #3;
          check($sformatf("%s rst%0d out", nm, k), obs,
                ov(0,0,0,0,0,2'b10,1,2'b10,0), M_ALL);
          check($sformatf("%s rst%0d flags", nm, k), {13'd0, Flags},
                {13'd0, flags_m}, 17'hF);
          @(posedge clk); #1;
        end
        reset = 1'b1;
        return;
      end
      MemReady = q[i].mr;
      ALUFlags = fix_en ? fix_val : 4'($urandom);
      #3;
      check($sformatf("%s c%0d out", nm, i), obs, q[i].e, q[i].m);
      check($sformatf("%s c%0d flags", nm, i), {13'd0, Flags},
            {13'd0, flags_m}, 17'hF);
      @(posedge clk); #1;
      if (q[i].ex && ce) begin
        if (snz) flags_m[3:2] = ALUFlags[3:2];
        if (scv) flags_m[1:0] = ALUFlags[1:0];
      end
    end
  endtask

  initial begin
    logic [31:0] ins;
    logic [3:0]  cmd;
    logic [5:0]  fr;
    logic [3:0]  cmds [5];
    int          cls;
    cmds = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010};
    fix_en = 1'b0; fix_val = 4'd0;
    reset = 1'b0; Cond = 4'hE; Op = 2'b00; Funct = 6'd0; Rd = 4'd0;
    ALUFlags = 4'd0; MemReady = 1'b1; op_c = 2'b00; flags_m = 4'd0;

    @(posedge clk); @(posedge clk); #1;
    check("reset out", obs, ov(0,0,0,0,0,2'b10,1,2'b10,0), M_ALL);
    check("reset flags", {13'd0, Flags}, 17'd0, 17'hF);
    reset = 1'b1;

    run_instr(32'hE2802005, 0, 0, -1, "ADDI");
    run_instr(32'hE5802064, 1, 3, -1, "STR");
    run_instr(32'hE5902060, 0, 0, -1, "LDR");
    run_instr(32'hE5902060, 2, 2, -1, "LDRwait");
    fix_en = 1'b1; fix_val = 4'b0100;
    run_instr(32'hE1510002, 0, 0, -1, "CMP");
    fix_en = 1'b0;
    run_instr(32'h1AFFFFEF, 0, 0, -1, "BNE");
    run_instr(32'hEA000001, 0, 0, -1, "B");
    run_instr(32'hE086F003, 0, 0, -1, "ADDpc");
    run_instr(32'hE0612003, 0, 0, -1, "UNDEFop");
    run_instr(32'hF0812003, 0, 0, -1, "NV");
    run_instr(32'hEC000000, 0, 0, -1, "NOP");
    fix_en = 1'b1; fix_val = 4'b1011;
    run_instr(32'hE2912005, 0, 0, -1, "ADDS");
    fix_en = 1'b0;
    run_instr(32'hE0812003, 1, 0, 3, "RSTmid");
    run_instr(32'hE2802005, 0, 0, -1, "ADDpostrst");

    for (int n = 0; n < 60; n++) begin
      cls = $urandom_range(0, 5);
      cmd = cmds[$urandom_range(0, 4)];
      case (cls)
        0: ins = {4'($urandom), 2'b01, 5'($urandom), 1'b1, 20'($urandom)};
        1: ins = {4'($urandom), 2'b01, 5'($urandom), 1'b0, 20'($urandom)};
        2, 3: begin
          fr  = {(cls == 3), cmd, (cmd == 4'b1010) ? 1'b1 : 1'($urandom)};
          ins = {4'($urandom), 2'b00, fr, 20'($urandom)};
        end
        4: ins = {4'($urandom), 2'b10, 26'($urandom)};
        default: ins = {4'($urandom), 2'b11, 26'($urandom)};
      endcase
      run_instr(ins, $urandom_range(0, 2), $urandom_range(0, 2), -1,
                $sformatf("rnd%0d_%h", n, ins));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
